// File: rtl/calc_pkg.sv
// Shared calculator types: formatter FSM states, datapath sizes and the
// sign-and-magnitude result struct passed on from the arithmetic stage.
package calc_pkg;

  localparam int CALC_WIDTH  = 16;
  localparam int CALC_DIGITS = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fmt_state_t;

  typedef struct packed {
    logic                  sign;
    logic [CALC_WIDTH-1:0] mag;
  } sm_value_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // add-3 correction
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/sm_bcd_formatter.sv
// Sign-and-magnitude to packed BCD formatter, one magnitude bit per clock.
// Optional leading-zero blank mask built when SM_BCD_BLANK_EN is defined.
module sm_bcd_formatter
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH:0]        value,
  input  logic                  ovw_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovw,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  fmt_state_t      state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0] mag_r, mag_s;
  logic [BW-1:0]   scratch_r, scratch_s, corrected_s, final_s;
  logic [BW-1:0]   bcd_r, bcd_s;
  logic            sign_hold_r, sign_hold_s, ovw_hold_r, ovw_hold_s;
  logic            busy_r, busy_s, done_r, done_s, sign_r, sign_s, ovw_r, ovw_s;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_r[4*d +: 4]),
      .dout (corrected_s[4*d +: 4])
    );
  end

  // scratch value after this cycle's correct-then-shift step
  assign final_s = {corrected_s[BW-2:0], mag_r[WIDTH-1]};

  // next-state and output decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mag_s       = mag_r;
    scratch_s   = scratch_r;
    sign_hold_s = sign_hold_r;
    ovw_hold_s  = ovw_hold_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    bcd_s       = bcd_r;
    sign_s      = sign_r;
    ovw_s       = ovw_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          mag_s       = value[WIDTH-1:0];
          sign_hold_s = value[WIDTH];
          ovw_hold_s  = ovw_in;
          scratch_s   = {BW{1'b0}};
          cnt_s       = {CW{1'b0}};
          busy_s      = 1'b1;
          state_s     = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        scratch_s = final_s;
        mag_s     = {mag_r[WIDTH-2:0], 1'b0};
        cnt_s     = cnt_r + 1'b1;
        if (cnt_r == LAST) begin
          bcd_s   = final_s;
          // negative zero is shown as +0
          sign_s  = sign_hold_r & (final_s != {BW{1'b0}});
          ovw_s   = ovw_hold_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      mag_r       <= {WIDTH{1'b0}};
      scratch_r   <= {BW{1'b0}};
      sign_hold_r <= 1'b0;
      ovw_hold_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bcd_r       <= {BW{1'b0}};
      sign_r      <= 1'b0;
      ovw_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mag_r       <= mag_s;
      scratch_r   <= scratch_s;
      sign_hold_r <= sign_hold_s;
      ovw_hold_r  <= ovw_hold_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      bcd_r       <= bcd_s;
      sign_r      <= sign_s;
      ovw_r       <= ovw_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sign = sign_r;
  assign bcd  = bcd_r;
  assign ovw  = ovw_r;

`ifdef SM_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r;

  // digit i blanks when it and all higher digits are zero; digit 0 never blanks
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] digits);
    logic z;
    blank_mask = {DIGITS{1'b0}};
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (digits[4*i +: 4] == 4'd0);
      blank_mask[i] = z;
    end
  endfunction

  // blank mask register, updated with bcd
  always_ff @(posedge clock) begin
    if (reset) begin
      blank_r <= {DIGITS{1'b0}};
    end else if (done_s) begin
      blank_r <= blank_mask(final_s);
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank = blank_r;
`else
  assign blank = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_sm_bcd_formatter.sv
// Directed self-checking bench for sm_bcd_formatter; blank expectations
// follow SM_BCD_BLANK_EN.
module tb_sm_bcd_formatter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] value;
  logic        ovw_in;
  logic        busy, done, sign, ovw;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int tests_run = 0;
  int failed = 0;
  int lat;
  int dones;
  bit busy_ok;

  sm_bcd_formatter dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .value  (value),
    .ovw_in (ovw_in),
    .busy   (busy),
    .done   (done),
    .sign   (sign),
    .bcd    (bcd),
    .ovw    (ovw),
    .blank  (blank)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_blank(input logic [4:0] m);
`ifdef SM_BCD_BLANK_EN
    return m;
`else
    return 5'b00000 & m;
`endif
  endfunction

  // pulse start for one edge; returns at the negedge after acceptance
  task automatic do_start(input logic [16:0] v, input logic o);
    @(negedge clock);
    value = v; ovw_in = o; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // wait for done with a cycle budget; checks held outputs mid-conversion
  task automatic wait_done(input string tag, input logic [19:0] prev_bcd);
    lat = 0;
    busy_ok = 1'b1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == 8) check({tag, "_hold"}, {12'd0, bcd}, {12'd0, prev_bcd});
    end
    check({tag, "_latency"}, lat, 16);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; value = 17'd0; ovw_in = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {12'd0, bcd}, 32'd0);
    check("reset_sign_ovw", {30'd0, sign, ovw}, 32'd0);
    check("reset_blank", {27'd0, blank}, 32'd0);
    reset = 1'b0; start = 1'b0;

    // +12345
    do_start(17'h0_3039, 1'b0);
    wait_done("p12345", 20'h00000);
    check("p12345_bcd", {12'd0, bcd}, 32'h12345);
    check("p12345_sign_ovw", {30'd0, sign, ovw}, 32'd0);
    check("p12345_blank", {27'd0, blank}, {27'd0, exp_blank(5'b00000)});
    @(negedge clock);
    check("p12345_done_pulse", {31'd0, done}, 32'd0);
    check("p12345_bcd_held", {12'd0, bcd}, 32'h12345);

    // -65535 with overflow
    do_start(17'h1_FFFF, 1'b1);
    wait_done("m65535", 20'h12345);
    check("m65535_bcd", {12'd0, bcd}, 32'h65535);
    check("m65535_sign_ovw", {30'd0, sign, ovw}, 32'd3);
    check("m65535_blank", {27'd0, blank}, {27'd0, exp_blank(5'b00000)});

    // -0 shows as +0
    do_start(17'h1_0000, 1'b0);
    wait_done("m0", 20'h65535);
    check("m0_bcd", {12'd0, bcd}, 32'd0);
    check("m0_sign_ovw", {30'd0, sign, ovw}, 32'd0);
    check("m0_blank", {27'd0, blank}, {27'd0, exp_blank(5'b11110)});

    // +7
    do_start(17'h0_0007, 1'b0);
    wait_done("p7", 20'h00000);
    check("p7_bcd", {12'd0, bcd}, 32'h00007);
    check("p7_blank", {27'd0, blank}, {27'd0, exp_blank(5'b11110)});

    // +100 with start re-pulsed at cycles 3 and 10, then back-to-back +42
    do_start(17'h0_0064, 1'b0);
    dones = 0;
    value = 17'h0_0309;
    for (int c = 1; c <= 16; c++) begin
      start = (c == 3 || c == 10);
      @(negedge clock);
      if (done === 1'b1 && c < 16) dones++;
    end
    start = 1'b0;
    check("p100_early_done", dones, 0);
    check("p100_done", {31'd0, done}, 32'd1);
    check("p100_bcd", {12'd0, bcd}, 32'h00100);
    check("p100_blank", {27'd0, blank}, {27'd0, exp_blank(5'b11000)});
    value = 17'h0_002A; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("p42_busy_accept", {31'd0, busy}, 32'd1);
    wait_done("p42", 20'h00100);
    check("p42_bcd", {12'd0, bcd}, 32'h00042);
    check("p42_blank", {27'd0, blank}, {27'd0, exp_blank(5'b11100)});

    // reset mid-conversion of +999
    do_start(17'h0_03E7, 1'b0);
    repeat (7) @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    check("rst_blank", {27'd0, blank}, 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("rst_no_done", dones, 0);

    // +1 after the abort
    do_start(17'h0_0001, 1'b0);
    wait_done("p1", 20'h00000);
    check("p1_bcd", {12'd0, bcd}, 32'h00001);
    check("p1_blank", {27'd0, blank}, {27'd0, exp_blank(5'b11110)});

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
